// File: rtl/id_regfile_pkg.sv
// Shared pipeline definitions: default widths, the hardwired-zero register index
// and the register-index type used by the decode and forwarding units.
package id_regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/id_regfile_hazard_detect.sv
// Load-use hazard detection: purely combinational, shared by the register file
// and the forwarding unit.
module hazard_detect
  import id_regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              id_ex_mem_read,
  input  logic [ADDR_W-1:0] id_ex_rt,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              rs_used,
  input  logic              rt_used,
  output logic              stall
);

  logic load_live;
  logic rs_hit;
  logic rt_hit;

  // A load into $0 produces nothing a consumer can depend on.
  assign load_live = id_ex_mem_read && (id_ex_rt != ADDR_W'(REG_ZERO));
  assign rs_hit    = rs_used && (id_ex_rt == rs_addr);
  assign rt_hit    = rt_used && (id_ex_rt == rt_addr);
  assign stall     = load_live && (rs_hit || rt_hit);

endmodule

// File: rtl/id_regfile.sv
// Decode-stage register file with two combinational read ports and load-use stall.
// Optional same-cycle write-through is enabled by defining REGFILE_BYPASS_EN.
module id_regfile
  import id_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic              id_ex_mem_read,
  input  logic [ADDR_W-1:0] id_ex_rt,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              stall
);

  localparam int unsigned NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_en;
  logic              hazard;

  assign wr_en = wb_reg_write && (wb_write_reg != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wb_write_reg] <= wb_write_data;
    end
  end

  always_comb begin
    rs_data = regs[rs_addr];
    rt_data = regs[rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wb_write_reg == rs_addr)) rs_data = wb_write_data;
    if (wr_en && (wb_write_reg == rt_addr)) rt_data = wb_write_data;
`endif
    // Reset also masks the bypass path so nothing leaks out while rst_n is low.
    if (!rst_n || (rs_addr == ADDR_W'(REG_ZERO))) rs_data = '0;
    if (!rst_n || (rt_addr == ADDR_W'(REG_ZERO))) rt_data = '0;
  end

  hazard_detect #(
    .ADDR_W(ADDR_W)
  ) u_hazard (
    .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rt      (id_ex_rt),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_used       (rs_used),
    .rt_used       (rt_used),
    .stall         (hazard)
  );

  assign stall = hazard && rst_n;

endmodule

// File: tb/tb_id_regfile.sv
// Self-checking bench for id_regfile against an array-based reference model.
// Honours REGFILE_BYPASS_EN in the same way as the design.
module tb_id_regfile;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wb_reg_write = 1'b0;
  logic [AW-1:0] wb_write_reg = '0;
  logic [DW-1:0] wb_write_data = '0;
  logic [AW-1:0] rs_addr = '0;
  logic [AW-1:0] rt_addr = '0;
  logic          rs_used = 1'b0;
  logic          rt_used = 1'b0;
  logic          id_ex_mem_read = 1'b0;
  logic [AW-1:0] id_ex_rt = '0;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic          stall;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model [32];

  id_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (!rst_n || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wb_reg_write && wb_write_reg == a) return wb_write_data;
`endif
    return model[a];
  endfunction

  function automatic logic exp_stall();
    if (!rst_n || !id_ex_mem_read || id_ex_rt == 0) return 1'b0;
    return (rs_used && id_ex_rt == rs_addr) || (rt_used && id_ex_rt == rt_addr);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic idle();
    wb_reg_write = 1'b0; wb_write_reg = '0; wb_write_data = '0;
    rs_addr = '0; rt_addr = '0; rs_used = 1'b0; rt_used = 1'b0;
    id_ex_mem_read = 1'b0; id_ex_rt = '0;
  endtask

  // Advance one clock; the model commits what the write inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n && wb_reg_write && wb_write_reg != 0) model[wb_write_reg] = wb_write_data;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_model();
    idle();
    rst_n = 1'b0;
    rs_addr = 5; rt_addr = 4; rt_used = 1'b1; id_ex_mem_read = 1'b1; id_ex_rt = 4;
    @(negedge clk); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (rt_data !== '0) begin errors++; $display("FAIL reset_rt: got %h expected 0", rt_data); end
    // write attempted while held in reset must be ignored
    wb_reg_write = 1'b1; wb_write_reg = 5; wb_write_data = 32'h0BAD_F00D;
    tick();
    wb_reg_write = 1'b0;
    rst_n = 1'b1; #1;
    checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL reset_write_ignored: got %h expected 0", rs_data); end
    idle();
    wb_reg_write = 1'b1; wb_write_reg = 5; wb_write_data = 32'hDEAD_BEEF;
    tick();
    idle(); rs_addr = 5; #1;
    checks++; if (rs_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pre_reset_r5: got %h expected deadbeef", rs_data); end
    rt_addr = 4; rt_used = 1'b1; id_ex_mem_read = 1'b1; id_ex_rt = 4;
    wb_reg_write = 1'b1; wb_write_reg = 6; wb_write_data = 32'h6666_6666;
    #2 rst_n = 1'b0; clear_model(); #1;
    checks++; if (rs_data !== '0) begin errors++; $display("FAIL midrun_reset_rs: got %h expected 0", rs_data); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrun_reset_stall: got %b expected 0", stall); end
    tick();
    idle(); rst_n = 1'b1; rs_addr = 6; rt_addr = 5; #1;
    checks++; if (rs_data !== '0) begin errors++; $display("FAIL inflight_lost_r6: got %h expected 0", rs_data); end
    checks++; if (rt_data !== '0) begin errors++; $display("FAIL cleared_r5: got %h expected 0", rt_data); end
  endtask

  task automatic test_write_read();
    idle();
    wb_reg_write = 1'b1; wb_write_reg = 7; wb_write_data = 32'h1234_5678;
    tick();
    idle(); rs_addr = 7; rt_addr = 7; #1;
    checks++; if (rs_data !== 32'h1234_5678) begin errors++; $display("FAIL wr_rd_rs: got %h expected 12345678", rs_data); end
    checks++; if (rt_data !== 32'h1234_5678) begin errors++; $display("FAIL wr_rd_rt: got %h expected 12345678", rt_data); end
  endtask

  task automatic test_zero_reg();
    idle();
    wb_reg_write = 1'b1; wb_write_reg = 0; wb_write_data = 32'hFFFF_FFFF;
    rs_addr = 0; rt_addr = 0; #1;
    checks++; if (rs_data !== '0) begin errors++; $display("FAIL r0_same_cycle: got %h expected 0", rs_data); end
    tick();
    wb_reg_write = 1'b0; #1;
    checks++; if (rs_data !== '0) begin errors++; $display("FAIL r0_after_rs: got %h expected 0", rs_data); end
    checks++; if (rt_data !== '0) begin errors++; $display("FAIL r0_after_rt: got %h expected 0", rt_data); end
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] want;
    idle();
    wb_reg_write = 1'b1; wb_write_reg = 3; wb_write_data = 32'h11;
    tick();
    wb_write_data = 32'h22; rs_addr = 3; rt_addr = 3; #1;
`ifdef REGFILE_BYPASS_EN
    want = 32'h22;
`else
    want = 32'h11;
`endif
    checks++; if (rs_data !== want) begin errors++; $display("FAIL same_cycle_rs: got %h expected %h", rs_data, want); end
    checks++; if (rt_data !== want) begin errors++; $display("FAIL same_cycle_rt: got %h expected %h", rt_data, want); end
    tick();
    wb_reg_write = 1'b0; #1;
    checks++; if (rs_data !== 32'h22) begin errors++; $display("FAIL same_cycle_next: got %h expected 22", rs_data); end
  endtask

  task automatic test_load_use();
    idle();
    id_ex_mem_read = 1'b1; id_ex_rt = 4; rt_addr = 4; rt_used = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_rt_hit: got %b expected 1", stall); end
    rt_used = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_rt_unused: got %b expected 0", stall); end
    rt_used = 1'b1; id_ex_rt = 0; rt_addr = 0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_dest_r0: got %b expected 0", stall); end
    rt_used = 1'b0; rs_used = 1'b1; rs_addr = 9; id_ex_rt = 9; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_rs_hit: got %b expected 1", stall); end
    id_ex_mem_read = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_not_load: got %b expected 0", stall); end
  endtask

  task automatic test_stall_write();
    idle();
    id_ex_mem_read = 1'b1; id_ex_rt = 4; rt_addr = 4; rt_used = 1'b1;
    wb_reg_write = 1'b1; wb_write_reg = 31; wb_write_data = 32'hA5A5_A5A5; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_wr_stall: got %b expected 1", stall); end
    tick();
    idle(); rs_addr = 31; #1;
    checks++; if (rs_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL stall_wr_r31: got %h expected a5a5a5a5", rs_data); end
  endtask

  task automatic test_random();
    logic [DW-1:0] ers, ert;
    logic est;
    for (int n = 0; n < 400; n++) begin
      wb_reg_write   = ($urandom_range(0, 3) != 0);
      wb_write_reg   = AW'($urandom_range(0, 31));
      wb_write_data  = $urandom;
      rs_addr        = AW'($urandom_range(0, 31));
      rt_addr        = ($urandom_range(0, 4) == 0) ? rs_addr : AW'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) wb_write_reg = rs_addr;
      rs_used        = 1'($urandom);
      rt_used        = 1'($urandom);
      id_ex_mem_read = 1'($urandom);
      case ($urandom_range(0, 3))
        0: id_ex_rt = rs_addr;
        1: id_ex_rt = rt_addr;
        default: id_ex_rt = AW'($urandom_range(0, 31));
      endcase
      #1;
      ers = exp_read(rs_addr); ert = exp_read(rt_addr); est = exp_stall();
      checks++; if (rs_data !== ers) begin errors++; $display("FAIL rand_rs[%0d] r%0d: got %h expected %h", n, rs_addr, rs_data, ers); end
      checks++; if (rt_data !== ert) begin errors++; $display("FAIL rand_rt[%0d] r%0d: got %h expected %h", n, rt_addr, rt_data, ert); end
      checks++; if (stall !== est) begin errors++; $display("FAIL rand_stall[%0d]: got %b expected %b", n, stall, est); end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_same_cycle();
    test_load_use();
    test_stall_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_regfile.md
# id_regfile

Decode-stage register file: the consumer of the writeback result. It accepts one writeback per cycle from the WB stage (the value the writeback mux selects), provides two combinational read ports to the ID stage, and flags load-use hazards so the pipeline can stall. Storage is 32 × 32-bit, and $0 is hardwired to zero.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register index width (2^ADDR_W registers)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- wb_reg_write  in  1  writeback enable from WB stage
- wb_write_reg  in  ADDR_W  writeback destination index
- wb_write_data  in  DATA_W  writeback value (writeback mux output)
- rs_addr  in  ADDR_W  ID read port A index
- rt_addr  in  ADDR_W  ID read port B index
- rs_used  in  1  current ID instruction consumes rs
- rt_used  in  1  current ID instruction consumes rt
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_rt  in  ADDR_W  load destination in EX
- rs_data  out  DATA_W  read port A data
- rt_data  out  DATA_W  read port B data
- stall  out  1  load-use hazard; hold PC and IF/ID, bubble ID/EX

## Operation
- **Write:** on the rising edge, if rst_n=1, wb_reg_write=1 and wb_write_reg≠0, then regs[wb_write_reg] ← wb_write_data. Writes to index 0 are dropped silently.
- **Read:** rs_data and rt_data are combinational. Index 0 always reads 0.
- **Same-cycle write/read:** behaviour is set by REGFILE_BYPASS_EN (see Configuration).
- **Hazard:** stall = id_ex_mem_read & (id_ex_rt≠0) & ((rs_used & id_ex_rt==rs_addr) | (rt_used & id_ex_rt==rt_addr)). The output is combinational.
- **No state machine.** The only state is the register array.
- **Simultaneous events:**
  - rs_addr==rt_addr: both ports return the same value.
  - A write and a hazard in the same cycle are independent; the write still commits.

## Timing
- **Reset:**
  - rst_n low clears all registers to 0 immediately, without waiting for clk.
  - While rst_n=0: rs_data=0, rt_data=0, stall=0, and writes are ignored.
- **Reset release:** the first write can commit on the first rising edge with rst_n=1.
- **Write latency:** a value is visible at the outputs on the cycle after the capturing edge. It is visible in the same cycle when the bypass is enabled.
- **Read latency:** 0 cycles, combinational from the address inputs.
- **Stall:** 0-cycle combinational assertion. It deasserts once the load advances out of EX (id_ex_mem_read drops after the bubble).
- **Reset mid-operation:** an in-flight writeback is lost, and all contents return to 0.

## Configuration
- **REGFILE_BYPASS_EN defined:**
  - When wb_reg_write=1, wb_write_reg≠0 and wb_write_reg equals a read index, that port returns wb_write_data in the same cycle (write-through).
  - The pipeline then needs no WB→ID forwarding.
- **Not defined:**
  - The ports return the stored (old) value until the edge.
  - An external WB→ID forward or an extra stall is required.
  - The hazard logic is unchanged.

## Structure
- **Shared pipeline package holds:**
  - DATA_W and ADDR_W defaults
  - REG_ZERO = 0
  - The register-index typedef, shared with the decode and forwarding units
- **Sub-module `hazard_detect`:** purely combinational stall logic, reusable by the forwarding unit. The array and read/bypass logic stay in id_regfile.

## Test plan
1. **Reset:** assert rst_n=0 mid-run after writing r5=0xDEADBEEF. Required: rs_addr=5 gives rs_data=0 immediately, and stall=0.
2. **Write then read:** write r7=0x12345678. Required: the next cycle, rs_addr=7 and rt_addr=7 both give 0x12345678.
3. **$0 protection:** write r0=0xFFFFFFFF. Required: reading r0 gives 0 in every cycle.
4. **Same-cycle write/read:** r3 holds 0x11; write r3=0x22 while rs_addr=3.
   - With REGFILE_BYPASS_EN: rs_data=0x22 in that cycle.
   - Without it: rs_data=0x11, then 0x22 the next cycle.
5. **Load-use:**
   - id_ex_mem_read=1, id_ex_rt=4, rt_addr=4, rt_used=1 → stall=1.
   - rt_used=0 → stall=0.
   - id_ex_rt=0 → stall=0.
6. **Write to r31 during a stall:** write r31=0xA5A5A5A5 while stall=1. Required: it commits, and a read of r31 the next cycle gives 0xA5A5A5A5.
